// File: rtl/minv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minv_pkg
//  Brief    : Shared types and constants for the MINV/MDIV result unload path.
//  Revision : 1.0
// ============================================================================
package minv_pkg;

    localparam int MINV_WIDTH = 16;
    localparam int MINV_WORDS = 16;
    localparam int MINV_CNT_W = $clog2(MINV_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_ERR    = 2'd2,
        ST_FIN    = 2'd3
    } minv_state_t;

endpackage : minv_pkg
`default_nettype wire

// File: rtl/minv_result_unload.sv
`default_nettype none
// ============================================================================
//  Module   : minv_result_unload
//  Brief    : Streams the x1/x2 cyclic result register to the host, LSW first.
//  Revision : 1.0
// ============================================================================
module minv_result_unload
    import minv_pkg::*;
#(
    parameter int WIDTH = MINV_WIDTH,
    parameter int WORDS = MINV_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             res_sel,
    input  logic             minv_flag,
    input  logic [WIDTH-1:0] regx1out,
    input  logic [WIDTH-1:0] regx2out,
    output logic             regx1_cyc,
    output logic             regx2_cyc,
    output logic [WIDTH-1:0] dataout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             dout_err,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WORDS - 1);

    minv_state_t        r_state;
    minv_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic               r_sel;
    logic               r_flag;
    logic               w_beat;
    logic               w_last;

    assign w_last = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_sel   <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && start) begin
                r_sel   <= res_sel;
                r_flag  <= minv_flag;
                r_count <= '0;
            end else if (r_state == ST_STREAM && w_beat) begin
                // Cleared explicitly so non power-of-two WORDS also restart at zero.
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        regx1_cyc   = 1'b0;
        regx2_cyc   = 1'b0;
        dataout     = '0;
        dout_valid  = 1'b0;
        dout_last   = 1'b0;
        dout_err    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = minv_flag ? ST_ERR : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                dout_last  = w_last;
                dataout    = r_sel ? regx2out : regx1out;
                w_beat     = dout_ready;
                // Rotate in the accepting cycle so the next word is ready at the next edge.
                regx1_cyc  = w_beat & ~r_sel;
                regx2_cyc  = w_beat &  r_sel;
                if (w_beat && w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_ERR: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                dout_last  = 1'b1;
                dout_err   = r_flag;
                if (dout_ready) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : minv_result_unload
`default_nettype wire

// File: tb/tb_minv_result_unload.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minv_result_unload
//  Brief    : Directed self-checking bench with x1/x2 cyclic register models.
//  Revision : 1.0
// ============================================================================
module tb_minv_result_unload;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        res_sel;
    logic        minv_flag;
    logic [15:0] regx1out;
    logic [15:0] regx2out;
    logic        regx1_cyc;
    logic        regx2_cyc;
    logic [15:0] dataout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        dout_err;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] x1_mem [16];
    logic [15:0] x2_mem [16];
    logic [15:0] pat = 16'h4B3A;

    always #5 clk = ~clk;

    minv_result_unload #(.WIDTH(16), .WORDS(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .res_sel    (res_sel),
        .minv_flag  (minv_flag),
        .regx1out   (regx1out),
        .regx2out   (regx2out),
        .regx1_cyc  (regx1_cyc),
        .regx2_cyc  (regx2_cyc),
        .dataout    (dataout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .dout_err   (dout_err),
        .busy       (busy),
        .done       (done)
    );

    assign regx1out = x1_mem[0];
    assign regx2out = x2_mem[0];

    // Cyclic register models: rotate one word toward the output on cyc.
    always @(posedge clk) begin
        if (regx1_cyc) begin
            for (int i = 0; i < 15; i++) x1_mem[i] <= x1_mem[i+1];
            x1_mem[15] <= x1_mem[0];
        end
        if (regx2_cyc) begin
            for (int i = 0; i < 15; i++) x2_mem[i] <= x2_mem[i+1];
            x2_mem[15] <= x2_mem[0];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check_val({tag, "_busy"},  {31'd0, busy},       32'd0);
        check_val({tag, "_done"},  {31'd0, done},       32'd0);
        check_val({tag, "_cyc"},   {30'd0, regx1_cyc, regx2_cyc}, 32'd0);
    endtask

    task automatic pulse_start(input bit sel, input bit flag);
        @(negedge clk);
        start = 1'b1; res_sel = sel; minv_flag = flag;
        @(negedge clk);
        start = 1'b0; res_sel = 1'b0; minv_flag = 1'b0;
    endtask

    // Streams one transfer and checks every cycle; expected word idx is base+((idx+off)%16).
    task automatic do_stream(input bit sel, input bit rnd, input logic [15:0] base,
                             input int off, input int restart_at);
        int idx = 0;
        int cyc_cnt = 0;
        int budget = 0;
        bit r;
        logic [15:0] exp_w;
        pulse_start(sel, 1'b0);
        while (idx < 16 && budget < 200) begin
            r = rnd ? pat[budget % 16] : 1'b1;
            start   = (idx == restart_at);
            res_sel = ~sel;
            dout_ready = r;
            #1;
            exp_w = base + 16'((idx + off) % 16);
            check_val("valid", {31'd0, dout_valid}, 32'd1);
            check_val("busy",  {31'd0, busy},       32'd1);
            check_val("data",  {16'd0, dataout},    {16'd0, exp_w});
            check_val("last",  {31'd0, dout_last},  {31'd0, idx == 15});
            check_val("err",   {31'd0, dout_err},   32'd0);
            check_val("cyc1",  {31'd0, regx1_cyc},  {31'd0, r && !sel});
            check_val("cyc2",  {31'd0, regx2_cyc},  {31'd0, r && sel});
            if (regx1_cyc || regx2_cyc) cyc_cnt++;
            if (r) idx++;
            @(negedge clk);
            budget++;
        end
        start = 1'b0; res_sel = 1'b0; dout_ready = 1'b0;
        check_val("beats", idx, 16);
        #1;
        check_val("done", {31'd0, done}, 32'd1);
        check_val("fin_valid", {31'd0, dout_valid}, 32'd0);
        check_val("fin_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_idle_outputs("post");
        end
        check_val("cyc_cnt", cyc_cnt, 16);
        check_val("align", {16'd0, sel ? x2_mem[0] : x1_mem[0]}, {16'd0, base + 16'(off)});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_sel = 1'b0; minv_flag = 1'b0; dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            x1_mem[i] = 16'(i);
            x2_mem[i] = 16'hA5A0 + 16'(i);
        end
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("rst");
        check_val("rst_data", {16'd0, dataout}, 32'd0);
        check_val("rst_last", {30'd0, dout_last, dout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain x1 stream, then with backpressure.
        do_stream(1'b0, 1'b0, 16'h0000, 0, -1);
        do_stream(1'b0, 1'b1, 16'h0000, 0, -1);

        // x2 select.
        do_stream(1'b1, 1'b0, 16'hA5A0, 0, -1);

        // No-inverse: one error beat, held once under backpressure.
        pulse_start(1'b0, 1'b1);
        dout_ready = 1'b0;
        #1;
        check_val("err_valid", {31'd0, dout_valid}, 32'd1);
        check_val("err_flag",  {31'd0, dout_err},   32'd1);
        check_val("err_last",  {31'd0, dout_last},  32'd1);
        check_val("err_data",  {16'd0, dataout},    32'd0);
        @(negedge clk);
        dout_ready = 1'b1;
        #1;
        check_val("err_hold", {31'd0, dout_valid & dout_err}, 32'd1);
        check_val("err_cyc",  {30'd0, regx1_cyc, regx2_cyc}, 32'd0);
        @(negedge clk);
        dout_ready = 1'b0;
        #1;
        check_val("err_done", {31'd0, done}, 32'd1);
        check_val("err_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
        check_idle_outputs("err_post");

        // Reset after the 5th accepted beat.
        pulse_start(1'b0, 1'b0);
        dout_ready = 1'b1;
        repeat (5) @(negedge clk);
        dout_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check_val("midrst_align", {16'd0, x1_mem[0]}, 32'd5);
        do_stream(1'b0, 1'b0, 16'h0000, 5, -1);

        // Start and rst together: rst wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        check_idle_outputs("rst_start");

        // Start while busy at beat 3 with res_sel toggled.
        do_stream(1'b1, 1'b1, 16'hA5A0, 0, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_minv_result_unload
`default_nettype wire

// File: doc/minv_result_unload.md
Name: minv_result_unload

Overview:
- Reads the modular-inversion/division result out of the datapath after the operation completes.
- Streams the selected 256-bit result register (x1 or x2 cyclic shift register) to the host as 16 words of 16 bits over a valid/ready handshake.
- Reports the no-inverse condition signalled by minv_flag.
- Counterpart of the 16-bit datain operand-load path. Sits between the MINV/MDIV controller/datapath and the host bus interface.

Parameters:
- WIDTH, 16, word width; equals the datapath word size.
- WORDS, 16, words per result; WIDTH*WORDS = 256.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse from the controller once minv_rdy is set.
- res_sel  input  1  0 = stream regx1, 1 = stream regx2; sampled on accepted start.
- minv_flag  input  1  1 = no inverse exists; sampled on accepted start.
- regx1out  input  WIDTH  low word of the x1 cyclic register.
- regx2out  input  WIDTH  low word of the x2 cyclic register.
- regx1_cyc  output  1  rotate x1 one word; to be ORed into the datapath regx1_cyc.
- regx2_cyc  output  1  rotate x2 one word.
- dataout  output  WIDTH  result word.
- dout_valid  output  1  dataout valid.
- dout_ready  input  1  host accepts the beat.
- dout_last  output  1  final beat of the transfer.
- dout_err  output  1  beat carries the no-inverse indication.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=1 at an edge) forces state IDLE and count=0. All outputs are 0: dout_valid, dout_last, dout_err, busy, done, regx1_cyc, regx2_cyc, dataout.
- FSM states: IDLE, STREAM, ERR, FIN.
- IDLE: on start, latch sel=res_sel and flag=minv_flag. Go to ERR if minv_flag=1, else STREAM. busy is set from the next cycle.
- Latency: start at edge T gives dout_valid=1 in the cycle after T.
- STREAM:
  - dout_valid=1.
  - dataout is combinational from regx1out or regx2out per sel.
  - dout_last=1 when count==WORDS-1.
  - A beat completes when dout_valid & dout_ready. In that cycle assert exactly one of regx1_cyc/regx2_cyc (per sel) and increment count.
  - The cyc output is a pure function of the handshake and sel, asserted in the same cycle, so the next word is present the following cycle.
  - On the beat with count==WORDS-1, go to FIN and clear count (4-bit counter wraps naturally).
- Backpressure: when dout_valid=1 and dout_ready=0, there is no cyc, and dataout/dout_last stay stable because the register does not rotate. No beat may be dropped or duplicated.
- Word order: least-significant word first. Exactly WORDS rotations per transfer, so the result register returns to its original alignment and can be re-read.
- ERR: dout_valid=1, dout_err=1, dout_last=1, dataout=0. No cyc is ever asserted. On handshake, go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- start while busy (STREAM/ERR/FIN) is ignored; sel and flag do not change.
- start and rst in the same cycle: rst wins.
- rst mid-stream: return to IDLE next edge; the result register is left partially rotated and the controller must not re-read it without reload.
- regx1_cyc and regx2_cyc are never asserted together. Both are 0 outside STREAM.
- dout_ready while dout_valid=0 has no effect.

Decomposition:
- Shared package minv_pkg holds:
  - the state enum (IDLE, STREAM, ERR, FIN);
  - the MINV_WIDTH=16 and MINV_WORDS=16 constants;
  - the count width, clog2(MINV_WORDS).
- No sub-module. FSM, counter and output mux are in one module of about 150 lines.

Test Plan:
- Result words: x1 model loaded with words 0x0000..0x000F (LSW first), res_sel=0, minv_flag=0, dout_ready=1.
  - Required: 16 consecutive beats with data 0x0000..0x000F.
  - dout_last only on 0x000F; done one cycle later.
  - regx1_cyc high exactly 16 cycles, regx2_cyc never high.
  - x1 model back at original alignment.
- Backpressure: same load with dout_ready = pseudo-random 50% pattern.
  - Required: same 16-word sequence, no duplicates or drops.
  - dataout stable during every stall; cyc asserted only on accepted beats.
- Register select: res_sel=1, x2 loaded with 0xA5A0..0xA5AF.
  - Required: these 16 words streamed; regx1_cyc stays 0.
- No-inverse: minv_flag=1 at start.
  - Required: single beat with dataout=0x0000, dout_err=1, dout_last=1; no cyc; done after handshake.
- Reset mid-stream: rst asserted after the 5th accepted beat.
  - Required: next cycle dout_valid=0, busy=0, all cyc=0, done=0.
  - A fresh start streams 16 beats, observed from the then-current alignment.
- Start while busy: a second start pulse at beat 3 with res_sel toggled.
  - Required: ignored; the original register continues; exactly one done.
